// File: rtl/mux_nx1_ser_pkg.sv
// Shared definitions for the lane mux / serializer family:
// default geometry, index-width helper and the IDLE/BUSY state view.
package mux_nx1_ser_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Ceiling log2 for sizing lane indices; callers keep n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_nx1_ser_lane_pick.sv
// Lowest-set-bit finder over a lane mask: index of the first set lane
// and a flag telling whether any lane is set at all.
module mux_nx1_ser_lane_pick
    import mux_nx1_ser_pkg::*;
#(
    parameter int LANES = DEF_LANES
) (
    input  logic [LANES-1:0]        mask,
    output logic [clog2(LANES)-1:0] idx,
    output logic                    found
);

    localparam int IDX_W = clog2(LANES);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign found = |mask;

endmodule

// File: rtl/mux_nx1_ser.sv
// Captures a group of LANES lanes and emits them one per clock on a single
// WIDTH-bit output, lowest lane first, optionally skipping invalid lanes.
module mux_nx1_ser
    import mux_nx1_ser_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LANES        = DEF_LANES,
    parameter bit SKIP_INVALID = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [LANES-1:0]         lane_valid,
    input  logic                     in_load,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     validout,
    output logic [clog2(LANES)-1:0]  lane_idx,
    output logic                     overrun
);

    localparam int IDX_W = clog2(LANES);

    logic [LANES*WIDTH-1:0] hold;
    logic [LANES-1:0]       pending;
    logic [LANES-1:0]       vmask;
    state_e                 state;

    logic                   accept;
    logic [LANES-1:0]       load_mask;
    logic [LANES-1:0]       pick_mask;
    logic [LANES-1:0]       pick_vmask;
    logic [LANES*WIDTH-1:0] pick_data;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic [WIDTH-1:0]       pick_lane;
    logic                   pick_valid;

    assign state    = (pending == '0) ? ST_IDLE : ST_BUSY;
    assign in_ready = reset && (state == ST_IDLE);
    assign accept   = in_load && in_ready;

    // On an accepting edge the first lane comes straight from the inputs,
    // so the group's first output appears without waiting for the capture.
    assign load_mask  = SKIP_INVALID ? lane_valid : {LANES{1'b1}};
    assign pick_mask  = accept ? load_mask  : pending;
    assign pick_vmask = accept ? lane_valid : vmask;
    assign pick_data  = accept ? in_data    : hold;

    mux_nx1_ser_lane_pick #(
        .LANES (LANES)
    ) u_lane_pick (
        .mask  (pick_mask),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign pick_lane  = pick_data[int'(pick_idx) * WIDTH +: WIDTH];
    assign pick_valid = pick_vmask[pick_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold     <= '0;
            vmask    <= '0;
            pending  <= '0;
            out      <= '0;
            validout <= 1'b0;
            lane_idx <= '0;
            overrun  <= 1'b0;
        end else begin
            if (in_load && !in_ready) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                hold  <= in_data;
                vmask <= lane_valid;
            end
            if (pick_found) begin
                pending  <= pick_mask & ~(LANES'(1) << pick_idx);
                out      <= pick_valid ? pick_lane : '0;
                validout <= pick_valid;
                lane_idx <= pick_idx;
            end else begin
                pending  <= '0;
                out      <= '0;
                validout <= 1'b0;
                lane_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_ser.sv
// Bench for mux_nx1_ser: one instance per SKIP_INVALID setting, each paired
// with a queue-based reference of the lanes still owed to the output.
module tb_mux_nx1_ser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  lane_valid = '0;
    logic        in_load = 1'b0;

    int total = 0;
    int bad = 0;

    wire [12:0] act_vec [2];
    wire [12:0] exp_vec [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [7:0]  out;
        logic        validout;
        logic [1:0]  lane_idx;
        logic        in_ready;
        logic        overrun;

        logic [10:0] q[$];
        logic [10:0] ent;
        logic [7:0]  e_out = '0;
        logic        e_vld = 1'b0;
        logic [1:0]  e_idx = '0;
        logic        e_ovr = 1'b0;
        int          e_cnt = 0;

        mux_nx1_ser #(
            .WIDTH        (8),
            .LANES        (4),
            .SKIP_INVALID (g == 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_data    (in_data),
            .lane_valid (lane_valid),
            .in_load    (in_load),
            .in_ready   (in_ready),
            .out        (out),
            .validout   (validout),
            .lane_idx   (lane_idx),
            .overrun    (overrun)
        );

        // Reference: a load turns into a list of {valid, idx, data} entries,
        // each edge pops one entry onto the output.
        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                q.delete();
                e_out = '0; e_vld = 1'b0; e_idx = '0; e_ovr = 1'b0; e_cnt = 0;
            end else begin
                if (in_load && q.size() == 0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (g == 0 || lane_valid[k])
                            q.push_back({lane_valid[k], 2'(k),
                                         lane_valid[k] ? in_data[k*8 +: 8] : 8'h00});
                    end
                end else if (in_load) begin
                    e_ovr = 1'b1;
                end
                if (q.size() > 0) begin
                    ent = q.pop_front();
                    {e_vld, e_idx, e_out} = ent;
                end else begin
                    e_out = '0; e_vld = 1'b0; e_idx = '0;
                end
                e_cnt = q.size();
            end
        end

        assign act_vec[g] = {out, validout, lane_idx, in_ready, overrun};
        assign exp_vec[g] = {e_out, e_vld, e_idx, reset && (e_cnt == 0), e_ovr};
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            total++;
            if (act_vec[g] !== 13'h0) begin
                bad++;
                $display("FAIL reset_state dut%0d: got %h want %h", g, act_vec[g], 13'h0);
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if ({gen_dut[0].in_ready, gen_dut[1].in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 11",
                     {gen_dut[0].in_ready, gen_dut[1].in_ready});
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(gen_dut[0].in_ready && gen_dut[1].in_ready) && n < 16) begin
            @(negedge clk);
            n++;
            for (int g = 0; g < 2; g++) begin
                total++;
                if (act_vec[g] !== exp_vec[g]) begin
                    bad++;
                    $display("FAIL %s_drain dut%0d: got %h want %h", tag, g, act_vec[g], exp_vec[g]);
                end
            end
        end
        total++;
        if (!(gen_dut[0].in_ready && gen_dut[1].in_ready)) begin
            bad++;
            $display("FAIL %s_timeout: ready got %b want 11", tag,
                     {gen_dut[0].in_ready, gen_dut[1].in_ready});
        end
    endtask

    task automatic test_skip0_pattern();
        logic [10:0] want [4];
        want[0] = {1'b1, 2'd0, 8'h11};
        want[1] = {1'b1, 2'd1, 8'h22};
        want[2] = {1'b0, 2'd2, 8'h00};
        want[3] = {1'b1, 2'd3, 8'h44};
        in_data = 32'h44332211;
        lane_valid = 4'b1011;
        in_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_load = 1'b0;
            total++;
            if ({gen_dut[0].validout, gen_dut[0].lane_idx, gen_dut[0].out} !== want[i]) begin
                bad++;
                $display("FAIL skip0_lane%0d: got %h want %h", i,
                         {gen_dut[0].validout, gen_dut[0].lane_idx, gen_dut[0].out}, want[i]);
            end
            for (int g = 0; g < 2; g++) begin
                total++;
                if (act_vec[g] !== exp_vec[g]) begin
                    bad++;
                    $display("FAIL skip0_model dut%0d: got %h want %h", g, act_vec[g], exp_vec[g]);
                end
            end
        end
        wait_idle("skip0");
    endtask

    task automatic test_skip1_pattern();
        logic [11:0] want [2];
        want[0] = {1'b0, 1'b1, 2'd1, 8'h22};
        want[1] = {1'b1, 1'b1, 2'd3, 8'h44};
        in_data = 32'h44332211;
        lane_valid = 4'b1010;
        in_load = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_load = 1'b0;
            total++;
            if ({gen_dut[1].in_ready, gen_dut[1].validout, gen_dut[1].lane_idx, gen_dut[1].out} !== want[i]) begin
                bad++;
                $display("FAIL skip1_lane%0d: got %h want %h", i,
                         {gen_dut[1].in_ready, gen_dut[1].validout, gen_dut[1].lane_idx, gen_dut[1].out}, want[i]);
            end
            for (int g = 0; g < 2; g++) begin
                total++;
                if (act_vec[g] !== exp_vec[g]) begin
                    bad++;
                    $display("FAIL skip1_model dut%0d: got %h want %h", g, act_vec[g], exp_vec[g]);
                end
            end
        end
        wait_idle("skip1");
    endtask

    task automatic test_back_to_back();
        in_data = $urandom;
        lane_valid = 4'b1111;
        in_load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if ({gen_dut[0].validout, gen_dut[0].in_ready} !== {1'b1, (i == 3 || i == 7)}) begin
                bad++;
                $display("FAIL b2b_cycle%0d: valid/ready got %b%b want 1%b", i,
                         gen_dut[0].validout, gen_dut[0].in_ready, (i == 3 || i == 7));
            end
            for (int g = 0; g < 2; g++) begin
                total++;
                if (act_vec[g] !== exp_vec[g]) begin
                    bad++;
                    $display("FAIL b2b_model dut%0d: got %h want %h", g, act_vec[g], exp_vec[g]);
                end
            end
            in_load = (i == 3);
            if (i == 3) in_data = $urandom;
        end
        in_load = 1'b0;
        wait_idle("b2b");
    endtask

    task automatic test_overrun();
        in_data = $urandom;
        lane_valid = 4'b1111;
        in_load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                total++;
                if (act_vec[g] !== exp_vec[g]) begin
                    bad++;
                    $display("FAIL overrun_model dut%0d: got %h want %h", g, act_vec[g], exp_vec[g]);
                end
            end
        end
        in_load = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if ({gen_dut[0].overrun, gen_dut[1].overrun} !== 2'b11) begin
            bad++;
            $display("FAIL overrun_sticky: got %b want 11", {gen_dut[0].overrun, gen_dut[1].overrun});
        end
        wait_idle("overrun");
    endtask

    task automatic test_reset_mid_group();
        in_data = $urandom;
        lane_valid = 4'b1111;
        in_load = 1'b1;
        @(negedge clk);
        in_load = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            total++;
            if (act_vec[g] !== 13'h0) begin
                bad++;
                $display("FAIL midreset_clear dut%0d: got %h want %h", g, act_vec[g], 13'h0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({gen_dut[0].validout, gen_dut[0].in_ready, gen_dut[1].validout, gen_dut[1].in_ready} !== 4'b0101) begin
                bad++;
                $display("FAIL midreset_residual%0d: valid/ready got %b want 0101", i,
                         {gen_dut[0].validout, gen_dut[0].in_ready, gen_dut[1].validout, gen_dut[1].in_ready});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_empty_mask();
        in_data = 32'hA5C3_5AB7;
        lane_valid = 4'b0000;
        in_load = 1'b1;
        @(negedge clk);
        total++;
        if ({gen_dut[1].validout, gen_dut[1].in_ready, gen_dut[1].out} !== {2'b01, 8'h00}) begin
            bad++;
            $display("FAIL empty_mask: valid/ready/out got %b%b/%h want 01/00",
                     gen_dut[1].validout, gen_dut[1].in_ready, gen_dut[1].out);
        end
        lane_valid = 4'b0001;
        @(negedge clk);
        in_load = 1'b0;
        total++;
        if ({gen_dut[1].validout, gen_dut[1].lane_idx, gen_dut[1].out} !== {1'b1, 2'd0, 8'hB7}) begin
            bad++;
            $display("FAIL empty_then_one: got %h want %h",
                     {gen_dut[1].validout, gen_dut[1].lane_idx, gen_dut[1].out}, {1'b1, 2'd0, 8'hB7});
        end
        for (int g = 0; g < 2; g++) begin
            total++;
            if (act_vec[g] !== exp_vec[g]) begin
                bad++;
                $display("FAIL empty_model dut%0d: got %h want %h", g, act_vec[g], exp_vec[g]);
            end
        end
        wait_idle("empty");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_load = ($urandom_range(0, 9) < 4);
            in_data = $urandom;
            lane_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                total++;
                if (act_vec[g] !== exp_vec[g]) begin
                    bad++;
                    $display("FAIL random_c%0d dut%0d: got %h want %h", i, g, act_vec[g], exp_vec[g]);
                end
            end
        end
        in_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_skip0_pattern();
        test_skip1_pattern();
        test_back_to_back();
        test_overrun();
        test_reset_mid_group();
        test_empty_mask();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nx1_ser.md
MUX_NX1_SER -- requirements
Module: mux_nx1_ser

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per lane.
REQ-002 SHALL have parameter LANES, default 4: lane count; power of two, 2..16.
REQ-003 SHALL have parameter SKIP_INVALID, default 0: when 1, invalid lanes are skipped and not emitted.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, LANES*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port lane_valid, input, LANES: per-lane valid mask, bit k for lane k.
REQ-008 SHALL have port in_load, input, 1: group load strobe.
REQ-009 SHALL have port in_ready, output, 1: block accepts a group this cycle.
REQ-010 SHALL have port out, output, WIDTH: serialized lane data (registered).
REQ-011 SHALL have port validout, output, 1: out holds a valid lane (registered).
REQ-012 SHALL have port lane_idx, output, clog2(LANES): source lane of the current out (registered).
REQ-013 SHALL have port overrun, output, 1: sticky flag for a load attempted while not ready.

Function
REQ-014 SHALL hold the captured group in a data holding register plus a LANES-bit pending mask.
REQ-015 SHALL drive in_ready combinationally as (pending == 0) while reset is high; in_ready SHALL be 0 while reset is low.
REQ-016 SHALL accept a group only on a clk edge with in_load=1 and in_ready=1.
REQ-017 On acceptance, SHALL capture in_data; pending SHALL load lane_valid when SKIP_INVALID=1, else all-ones.
REQ-018 On the acceptance edge, the first lane SHALL already be loaded into out/validout/lane_idx (latency 1 edge), and its pending bit SHALL be cleared.
REQ-019 At each later edge with pending != 0, the lowest-index pending lane SHALL be emitted and its bit cleared, one lane per edge, in ascending order.
REQ-020 SKIP_INVALID=0: each emitted lane k SHALL drive validout=lane_valid[k] as captured; when that bit is 0, out SHALL be 0 (lane_idx still k); a group always takes exactly LANES edges.
REQ-021 SKIP_INVALID=1: only valid lanes SHALL be emitted, back-to-back, each with validout=1; a group takes popcount(mask) edges.
REQ-022 SKIP_INVALID=1 with an all-zero mask: the load SHALL be accepted, nothing emitted, validout stays 0, and in_ready stays 1.
REQ-023 Back-to-back: a load in the cycle in which the last lane is on out SHALL emit the new group's first lane on the next edge, with zero bubbles.
REQ-024 At an edge with pending == 0 and no accepted load: out, validout and lane_idx SHALL be set to 0.
REQ-025 in_load=1 with in_ready=0 SHALL be ignored (no state change) and SHALL set overrun=1.
REQ-026 overrun SHALL be cleared only by reset.
REQ-027 FSM view: IDLE (pending==0) and BUSY (pending!=0); transitions occur only per REQ-016..REQ-021.

Reset
REQ-028 reset low SHALL asynchronously clear out, validout, lane_idx, the pending mask, the holding register and overrun to 0, aborting any group in flight.
REQ-029 The first load SHALL be accepted no earlier than the first edge after reset deasserts.

Structure
REQ-030 A shared include file SHALL hold the clog2 function and the default WIDTH/LANES constants; other mux/serializer blocks SHALL reuse it.
REQ-031 A single sub-module lane_pick SHALL be used: combinational lowest-set-bit finder giving index and found flag over a LANES-bit mask.
REQ-032 The RTL SHALL be synthesizable with Yosys and simulate under Icarus.

Verification
REQ-033 SKIP=0, LANES=4, load d={0x44,0x33,0x22,0x11} (lane3..0), mask 1011 -> out 0x11/1, 0x22/1, 0x00/0 (idx2), 0x44/1 on edges t..t+3.
REQ-034 SKIP=1, same data, mask 1010 -> 0x22 (idx1), then 0x44 (idx3); in_ready=1 after the second edge.
REQ-035 Two groups loaded back-to-back -> 8 consecutive validout cycles, no gap; in_ready high only in the last-lane cycles.
REQ-036 in_load held high throughout BUSY -> later loads ignored, overrun=1 and sticky until reset.
REQ-037 reset pulsed low mid-group (after lane 1) -> outputs 0 immediately; after release, in_ready=1 and no residual lanes are emitted.
REQ-038 SKIP=1 with mask 0000, then a load with mask 0001 on the next cycle -> the first produces no output; the second emits idx0 one edge later.
